// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the pipelined 64-bit core.
//   cond_e           : 4-bit B.cond condition codes (EQ..NV)
//   FLAG_N..FLAG_V   : bit positions inside a 4-bit NZCV flag vector
//   DATA_W           : default datapath width
//   REG_ADDR_W       : default register-file address width
package cpu_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    HS = 4'h2,
    LO = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval
// Purely combinational B.cond evaluator, shared with later branch
// predictor / verifier logic.
// Ports:
//   flags     in  4  NZCV vector (bit 3 = N, bit 0 = V)
//   cond      in  4  condition code
//   cond_true out 1  condition holds for the given flags
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Straight decode of the condition table; AL and NV both mean "always".
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      EQ: cond_true = z;
      NE: cond_true = ~z;
      HS: cond_true = c;
      LO: cond_true = ~c;
      MI: cond_true = n;
      PL: cond_true = ~n;
      VS: cond_true = v;
      VC: cond_true = ~v;
      HI: cond_true = c & ~z;
      LS: cond_true = ~c | z;
      GE: cond_true = (n == v);
      LT: cond_true = (n != v);
      GT: cond_true = ~z & (n == v);
      LE: cond_true = z | (n != v);
      AL: cond_true = 1'b1;
      NV: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register of the 64-bit core. Captures ALU result, store
// data, destination and MEM/WB controls, owns the architectural NZCV flag
// register and resolves conditional branches into a registered branch_taken.
// Optional: define EX_MEM_PERF_CNT_EN to add perf_retired / perf_taken
// 32-bit event counters.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   stall, flush                      hold / kill the instruction in EX
//   in_valid, alu_*, set_flags        EX-stage instruction and ALU flags
//   store_data, rd, reg_write,
//   mem_read, mem_write               data and downstream controls
//   is_bcond/is_cbz/is_cbnz/is_uncond branch class, cond, branch_target
//   out_*                             registered MEM-stage copies
//   branch_taken, out_branch_target   registered branch decision / target
//   flags_q                           committed NZCV
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_negative,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_carry_out,
  input  logic                  set_flags,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  is_bcond,
  input  logic                  is_cbz,
  input  logic                  is_cbnz,
  input  logic                  is_uncond,
  input  logic [3:0]            cond,
  input  logic [DATA_W-1:0]     branch_target,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_result,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     out_branch_target,
  output logic [3:0]            flags_q
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_taken
`endif
);

  logic cond_true;
  logic taken;

  // B.cond looks at the committed flags, so an instruction that both sets
  // flags and branches sees the flags from before itself.
  cond_eval u_cond_eval (
    .flags     (flags_q),
    .cond      (cond),
    .cond_true (cond_true)
  );

  // CBZ/CBNZ test the ALU zero flag; the ALU passes the tested register
  // straight through on those instructions.
  assign taken = is_uncond
               | (is_cbz   &  alu_zero)
               | (is_cbnz  & ~alu_zero)
               | (is_bcond &  cond_true);

  // Stage register. Flush only clears validity and controls; data registers
  // simply hold since their value is don't-care for a killed slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_result        <= '0;
      out_store_data    <= '0;
      out_rd            <= '0;
      out_reg_write     <= 1'b0;
      out_mem_read      <= 1'b0;
      out_mem_write     <= 1'b0;
      branch_taken      <= 1'b0;
      out_branch_target <= '0;
      flags_q           <= 4'b0000;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      branch_taken  <= 1'b0;
    end else if (!stall) begin
      out_valid         <= in_valid;
      out_result        <= alu_result;
      out_store_data    <= store_data;
      out_rd            <= rd;
      out_reg_write     <= reg_write & in_valid;
      out_mem_read      <= mem_read & in_valid;
      out_mem_write     <= mem_write & in_valid;
      branch_taken      <= taken & in_valid;
      out_branch_target <= branch_target;
      if (in_valid && set_flags) begin
        flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      end
    end
  end

`ifdef EX_MEM_PERF_CNT_EN
  // Event counters follow the same capture condition as the stage register,
  // so they freeze on stall and ignore flushed slots; both wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired <= '0;
      perf_taken   <= '0;
    end else if (!flush && !stall) begin
      if (in_valid) begin
        perf_retired <= perf_retired + 32'd1;
      end
      if (in_valid && taken) begin
        perf_taken <= perf_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Registered boundary between the execute stage and the memory stage of the pipelined 64-bit core.
- Captures the ALU result, the ALU flags, the store data, the destination register and the memory/writeback controls.
- Holds the architectural NZCV flag register, updated only by flag-setting instructions.
- Resolves conditional branches (B.cond, CBZ, CBNZ) and drives a registered branch_taken to the fetch/flush logic.

Parameters:
- DATA_W, 64, datapath width (result, store data, branch target).
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold all stage registers and the flag register.
- flush  in  1  kill the instruction currently in EX.
- in_valid  in  1  an instruction is present in EX.
- alu_result  in  DATA_W  ALU result.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags.
- set_flags  in  1  instruction writes NZCV (ADDS/SUBS/ANDS).
- store_data  in  DATA_W  register value for STUR.
- rd  in  REG_ADDR_W  destination register.
- reg_write, mem_read, mem_write  in  1 each  downstream controls.
- is_bcond, is_cbz, is_cbnz, is_uncond  in  1 each  branch class; at most one set.
- cond  in  4  B.cond condition code.
- branch_target  in  DATA_W  computed target address.
- out_valid  out  1  MEM-stage instruction valid.
- out_result, out_store_data  out  DATA_W  registered copies.
- out_rd  out  REG_ADDR_W  registered copy.
- out_reg_write, out_mem_read, out_mem_write  out  1 each  registered controls, gated by validity.
- branch_taken  out  1  registered branch decision.
- out_branch_target  out  DATA_W  registered target.
- flags_q  out  4  architectural NZCV; bit 3 = N, bit 0 = V.

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
- Reset (reset_n low, asynchronous): every output and internal register is 0, including flags_q = 4'b0000.
- Latency: 1 cycle. Inputs sampled at a rising edge appear on the outputs after that edge.
- Priority per edge: reset, then flush, then stall, then normal capture.
- flush=1:
  - out_valid, all controls and branch_taken go to 0 at the next edge.
  - flags_q is not updated.
  - Data registers may take any value.
  - flush overrides a simultaneous stall.
- stall=1 (no flush): every register, including flags_q, holds its value; branch_taken holds.
- Normal capture, with v = in_valid:
  - out_valid <= v; out_result, out_store_data, out_rd and out_branch_target <= their inputs.
  - out_reg_write <= reg_write & v; out_mem_read <= mem_read & v; out_mem_write <= mem_write & v.
  - flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow} only if v & set_flags; otherwise it holds.
- Branch decision, registered as branch_taken <= v & taken:
  - taken = is_uncond | (is_cbz & alu_zero) | (is_cbnz & ~alu_zero) | (is_bcond & cond_true).
  - CBZ/CBNZ use the ALU zero flag. The ALU passes B through on these instructions.
- cond_true is evaluated against flags_q, the current committed flags, never against same-cycle ALU flags. An instruction that sets both set_flags and is_bcond therefore uses the old flags.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V.
  - C GT !Z&(N==V); D LE Z|(N!=V); E and F always.
- Back-to-back case: an ADDS followed directly by a B.cond sees the ADDS flags, because flags_q updates on the ADDS capture edge.
- Reset mid-operation: everything clears immediately with no waiting for an edge. The first valid capture occurs at the first edge after reset_n rises.

Optional Feature:
- Macro EX_MEM_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - perf_retired [31:0]: counts edges where out_valid is loaded with 1.
  - perf_taken [31:0]: counts edges where branch_taken is loaded with 1.
- Counter rules:
  - Reset to 0; wrap modulo 2^32.
  - Frozen under stall; not incremented for flushed instructions.
- When not defined, the ports and counters are absent, with no other change.

Decomposition:
- Shared package cpu_pkg holds:
  - the cond_e enum (EQ..NV, 4 bits);
  - NZCV bit-index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - DATA_W and REG_ADDR_W defaults.
- One sub-module, cond_eval: purely combinational (flags[3:0], cond[3:0]) -> cond_true. It is reused by any later branch predictor/verifier.

Test Plan:
- Reset: hold reset_n=0 mid-run with valid traffic -> all outputs 0 immediately; flags_q=0000.
- SUBS X1=5, X2=5 (alu_zero=1, carry=1, set_flags=1), then B.cond EQ next cycle -> flags_q=0110 after the first edge; branch_taken=1 after the second edge.
- CBNZ with alu_result=0, alu_zero=1 -> branch_taken=0. Repeat with alu_result=0x8, alu_zero=0 -> branch_taken=1, out_branch_target equals the input target.
- ADD (set_flags=0) producing alu_negative=1 after flags_q=0001 -> flags_q stays 0001. B.cond VS -> taken; VC -> not taken.
- Simultaneous stall=1 and flush=1 with in_valid=1, reg_write=1, set_flags=1 -> out_valid=0, out_reg_write=0, flags_q unchanged. Then stall alone for 3 cycles -> all outputs held bit-exact.
- Walk all 16 cond codes against flags 1001 (N=1, V=1) -> taken for NE, HS? no (C=0), LO, MI, VS, HI no, LS, GE, GT, AL, NV. Compare against a cond_eval reference model.
